cache_line_ctrl: RTL and testbench
==================================

# cache_line_ctrl

Parametrised write-back cache controller FSM that sits between the CPU load/store port and the cache data/tag arrays on one side and the next-level memory on the other. It generalises the single-beat cache controller to multi-word lines moved in bursts of `WORDS_PER_LINE` beats with a beat index, and adds a selectable write-miss policy. It also latches the request type across the miss sequence. Optional hit/miss performance counters can be compiled in.

## Interface
- `WORDS_PER_LINE`, 4: words per cache line and beats per memory burst; power of two, ≥1.
- `WRITE_ALLOCATE`, 1: 1 = write miss allocates the line; 0 = write miss writes around to memory, single beat.
- `CNT_W`, 32: perf counter width; used only with the macro.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_rden` in 1: CPU load request.
- `cpu_wren` in 1: CPU store request.
- `hit` in 1: tag match and valid for the current index.
- `dirty` in 1: victim line dirty.
- `mem_ready` in 1: memory accepted or returned the current beat.
- `cache_rden` out 1: read the cache data array.
- `cache_wren` out 1: write the cache data array.
- `cache_insel` out 1: cache write data source; 1 = memory, 0 = CPU.
- `mem_rden` out 1: memory read burst active.
- `mem_wren` out 1: memory write burst active.
- `beat_idx` out BW: word within the line for the current beat; BW = max(1, $clog2(WORDS_PER_LINE)).
- `set_dirty` out 1: write dirty bit.
- `set_valid` out 1: write valid bit.
- `replace_tag` out 1: load the new tag.
- `stall` out 1: hold the CPU pipeline.
- `hit_cnt` out CNT_W: hits; present only with the macro.
- `miss_cnt` out CNT_W: misses; present only with the macro.

## Operation
- States are `IDLE`, `COMPARE_TAG`, `WRITE_BACK`, `ALLOCATE` and `WRITE_AROUND`.
- Unless a rule below sets them, all outputs are 0 in every state.
- **IDLE**
  - `stall = cpu_rden | cpu_wren`.
  - On a request, latch `req_wr = cpu_wren` and go to `COMPARE_TAG`.
  - If both enables are high, the request is a write.
- **COMPARE_TAG**, hit
  - `cache_rden = !req_wr`, `cache_wren = req_wr`, `set_dirty = req_wr`, `set_valid = 1`, `stall = 0`.
  - Next state is `IDLE`.
- **COMPARE_TAG**, miss
  - `stall = 1` and the beat counter clears.
  - Write miss with `WRITE_ALLOCATE = 0` goes to `WRITE_AROUND`.
  - Otherwise: `dirty` goes to `WRITE_BACK`; clean goes to `ALLOCATE`.
- **WRITE_BACK**
  - `cache_rden = 1`, `mem_wren = 1`, `stall = 1`, `beat_idx` = counter.
  - Each `mem_ready` increments the counter.
  - `mem_ready` on beat `WORDS_PER_LINE-1` clears the counter and goes to `ALLOCATE`.
- **ALLOCATE**
  - `mem_rden = 1`, `cache_insel = 1`, `cache_wren = mem_ready`, `stall = 1`, `beat_idx` = counter.
  - On the last ready beat, additionally assert `replace_tag = 1`, `set_valid = 1` and `set_dirty = 0`, then go to `COMPARE_TAG`.
  - The re-lookup then hits and performs the latched access.
- **WRITE_AROUND**
  - `mem_wren = 1`, `cache_insel = 0`, `beat_idx = 0`.
  - `stall = !mem_ready`; on `mem_ready` go to `IDLE`.
  - Cache arrays and tag are untouched.
- **Boundary rules**
  - `mem_ready` is ignored outside `WRITE_BACK`, `ALLOCATE` and `WRITE_AROUND`.
  - CPU enables are ignored outside `IDLE`; a request dropped mid-miss still completes using `req_wr`.
  - With `WORDS_PER_LINE = 1` every burst is one beat and `beat_idx` stays 0.
  - The counter wraps to 0 only on the last beat; it never exceeds `WORDS_PER_LINE-1`.

## Timing
- Reset:
  - State `IDLE`, counter 0, `req_wr = 0`.
  - All outputs 0, `beat_idx = 0`, perf counters 0.
  - Assertion mid-burst aborts immediately; memory-side cleanup is the memory's responsibility.
- Hit latency is 2 cycles: request in `IDLE`, then access in `COMPARE_TAG`.
- Clean miss latency is 2 + refill beats + 1 cycles, plus memory wait cycles.
- Dirty miss adds `WORDS_PER_LINE` write-back beats.
- All outputs are Moore/Mealy combinational from state, counter, `req_wr`, `hit`, `dirty` and `mem_ready`; there are no extra register stages.

## Configuration
- Macro: `CACHE_LINE_CTRL_PERF_EN`.
- Defined:
  - `hit_cnt` increments on each hit in `COMPARE_TAG`, including the post-refill re-lookup.
  - `miss_cnt` increments on each miss in `COMPARE_TAG`.
  - Both counters saturate at all-ones.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Package `cache_pkg` holds:
  - the state typedef `cache_state_e`, encoded in 3 bits;
  - the `WRITE_ALLOCATE` mode constants `CACHE_WA` / `CACHE_WNA`.
- Sub-module `cache_beat_counter`: parametrised counter with clear, increment and `last` flag.
- The FSM instantiates `cache_beat_counter` once.

## Test plan
- Read hit (`WORDS_PER_LINE=4`): `cpu_rden=1`, `hit=1` → `cache_rden=1` in cycle 2, `stall` 1 then 0, state back in `IDLE`.
- Clean write miss (`WRITE_ALLOCATE=1`): 4 ready beats → `beat_idx` 0,1,2,3 with `cache_wren` and `cache_insel`; `replace_tag` on beat 3; re-lookup hit gives `cache_wren=1`, `set_dirty=1`.
- Dirty read miss, `mem_ready` every other cycle → 4 `WRITE_BACK` beats, then 4 `ALLOCATE` beats; `stall` high for 18 cycles.
- `WRITE_ALLOCATE=0` write miss, `mem_ready` after 3 cycles → `mem_wren` for 3 cycles; no `cache_wren` or `replace_tag`; return to `IDLE`.
- `rst_n` low during `ALLOCATE` beat 2 → all outputs 0 immediately; after release a new request restarts at beat 0.
- With `CACHE_LINE_CTRL_PERF_EN` and `CNT_W=2`: 5 hits → `hit_cnt` saturates at 3; 1 miss → `miss_cnt=1`, and its re-lookup counts as a hit.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the write-back cache line controller.
// Holds the FSM state encoding and the write-miss policy constants.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    COMPARE_TAG  = 3'd1,
    WRITE_BACK   = 3'd2,
    ALLOCATE     = 3'd3,
    WRITE_AROUND = 3'd4
  } cache_state_e;

  localparam bit CACHE_WA  = 1'b1;
  localparam bit CACHE_WNA = 1'b0;

  // A one-word line still needs a 1-bit beat index.
  function automatic int beat_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Beat counter for line bursts: synchronous clear, increment, and a flag on
// the final beat. It wraps to zero only when incremented on the last beat.
module cache_beat_counter #(
  parameter int WORDS = 4,
  parameter int BW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [BW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == BW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + BW'(1);
    end
  end

endmodule

// File: rtl/cache_line_ctrl.sv
// Write-back cache controller FSM moving multi-word lines in beat bursts.
// Define CACHE_LINE_CTRL_PERF_EN to add saturating hit_cnt/miss_cnt ports.
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter bit WRITE_ALLOCATE = CACHE_WA,
  parameter int CNT_W          = 32,
  localparam int BW            = beat_width(WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_rden,
  input  logic          cpu_wren,
  input  logic          hit,
  input  logic          dirty,
  input  logic          mem_ready,
  output logic          cache_rden,
  output logic          cache_wren,
  output logic          cache_insel,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic [BW-1:0] beat_idx,
  output logic          set_dirty,
  output logic          set_valid,
  output logic          replace_tag,
`ifdef CACHE_LINE_CTRL_PERF_EN
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
`endif
  output logic          stall
);

  cache_state_e  state, next_state;
  logic          req_wr, next_req_wr;
  logic          cnt_clr, cnt_inc, cnt_last;
  logic [BW-1:0] cnt;

  cache_beat_counter #(
    .WORDS (WORDS_PER_LINE),
    .BW    (BW)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_wr <= 1'b0;
    end else begin
      state  <= next_state;
      req_wr <= next_req_wr;
    end
  end

  // The request type is latched in IDLE so a dropped request still completes.
  always_comb begin
    next_state  = state;
    next_req_wr = req_wr;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cache_rden  = 1'b0;
    cache_wren  = 1'b0;
    cache_insel = 1'b0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    beat_idx    = '0;
    set_dirty   = 1'b0;
    set_valid   = 1'b0;
    replace_tag = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        stall = cpu_rden | cpu_wren;
        if (cpu_rden || cpu_wren) begin
          next_req_wr = cpu_wren;
          next_state  = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        if (hit) begin
          cache_rden = !req_wr;
          cache_wren = req_wr;
          set_dirty  = req_wr;
          set_valid  = 1'b1;
          next_state = IDLE;
        end else begin
          stall   = 1'b1;
          cnt_clr = 1'b1;
          if (req_wr && (WRITE_ALLOCATE == CACHE_WNA)) begin
            next_state = WRITE_AROUND;
          end else if (dirty) begin
            next_state = WRITE_BACK;
          end else begin
            next_state = ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        cache_rden = 1'b1;
        mem_wren   = 1'b1;
        stall      = 1'b1;
        beat_idx   = cnt;
        if (mem_ready) begin
          cnt_inc = 1'b1;
          if (cnt_last) next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_rden    = 1'b1;
        cache_insel = 1'b1;
        cache_wren  = mem_ready;
        stall       = 1'b1;
        beat_idx    = cnt;
        if (mem_ready) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            replace_tag = 1'b1;
            set_valid   = 1'b1;
            next_state  = COMPARE_TAG;
          end
        end
      end
      WRITE_AROUND: begin
        mem_wren = 1'b1;
        stall    = !mem_ready;
        if (mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef CACHE_LINE_CTRL_PERF_EN
  // Lookups are counted in COMPARE_TAG only, so a refill re-lookup is a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == COMPARE_TAG) begin
      if (hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end else if (!hit && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed self-checking bench for cache_line_ctrl (allocate and no-allocate
// instances); perf counter checks are compiled in with CACHE_LINE_CTRL_PERF_EN.
module tb_cache_line_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rden = 1'b0, cpu_wren = 1'b0, hit = 1'b0, dirty = 1'b0, mem_ready = 1'b0;

  logic a_cache_rden, a_cache_wren, a_cache_insel, a_mem_rden, a_mem_wren;
  logic a_set_dirty, a_set_valid, a_replace_tag, a_stall;
  logic [1:0] a_beat_idx;
  logic b_cache_rden, b_cache_wren, b_cache_insel, b_mem_rden, b_mem_wren;
  logic b_set_dirty, b_set_valid, b_replace_tag, b_stall;
  logic [1:0] b_beat_idx;
`ifdef CACHE_LINE_CTRL_PERF_EN
  logic [1:0]  a_hit_cnt, a_miss_cnt;
  logic [31:0] b_hit_cnt, b_miss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int stall_cycles;
  int memwr_cycles;
  logic [8:0] exp_v;

  // Order: cache_rden cache_wren cache_insel mem_rden mem_wren set_dirty set_valid replace_tag stall
  wire [10:0] va = {a_cache_rden, a_cache_wren, a_cache_insel, a_mem_rden, a_mem_wren,
                    a_set_dirty, a_set_valid, a_replace_tag, a_stall, a_beat_idx};
  wire [10:0] vb = {b_cache_rden, b_cache_wren, b_cache_insel, b_mem_rden, b_mem_wren,
                    b_set_dirty, b_set_valid, b_replace_tag, b_stall, b_beat_idx};

  always #5 clk = ~clk;

  cache_line_ctrl #(.WORDS_PER_LINE(4), .WRITE_ALLOCATE(1'b1), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .hit(hit),
    .dirty(dirty), .mem_ready(mem_ready), .cache_rden(a_cache_rden),
    .cache_wren(a_cache_wren), .cache_insel(a_cache_insel), .mem_rden(a_mem_rden),
    .mem_wren(a_mem_wren), .beat_idx(a_beat_idx), .set_dirty(a_set_dirty),
    .set_valid(a_set_valid), .replace_tag(a_replace_tag),
`ifdef CACHE_LINE_CTRL_PERF_EN
    .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt),
`endif
    .stall(a_stall)
  );

  cache_line_ctrl #(.WORDS_PER_LINE(4), .WRITE_ALLOCATE(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .hit(hit),
    .dirty(dirty), .mem_ready(mem_ready), .cache_rden(b_cache_rden),
    .cache_wren(b_cache_wren), .cache_insel(b_cache_insel), .mem_rden(b_mem_rden),
    .mem_wren(b_mem_wren), .beat_idx(b_beat_idx), .set_dirty(b_set_dirty),
    .set_valid(b_set_valid), .replace_tag(b_replace_tag),
`ifdef CACHE_LINE_CTRL_PERF_EN
    .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt),
`endif
    .stall(b_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic rd, input logic wr, input logic h,
                               input logic d, input logic rdy);
    @(negedge clk);
    cpu_rden = rd; cpu_wren = wr; hit = h; dirty = d; mem_ready = rdy;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_rden = 1'b0; cpu_wren = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ready = 1'b0;
    #1;
    checkOutput("reset_a", {21'd0, va}, 32'd0);
    checkOutput("reset_b", {21'd0, vb}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // Read hit
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("hit_idle", {21'd0, va}, {21'd0, 9'b000000001, 2'd0});
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("hit_access", {21'd0, va}, {21'd0, 9'b100000100, 2'd0});
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hit_back_idle", {21'd0, va}, 32'd0);

    // Clean write miss with allocate; request dropped after IDLE
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("wmiss_idle", {21'd0, va}, {21'd0, 9'b000000001, 2'd0});
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wmiss_compare", {21'd0, va}, {21'd0, 9'b000000001, 2'd0});
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 1);
      exp_v = (k == 3) ? 9'b011100111 : 9'b011100001;
      checkOutput($sformatf("wmiss_alloc_beat%0d", k), {21'd0, va}, {21'd0, exp_v, 2'(k)});
    end
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wmiss_relookup", {21'd0, va}, {21'd0, 9'b010001100, 2'd0});
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wmiss_idle_after", {21'd0, va}, 32'd0);

    // Dirty read miss, mem_ready every other cycle
    stall_cycles = 0;
    applyStimulus(1, 0, 0, 1, 0);
    stall_cycles += int'(a_stall);
    checkOutput("dmiss_idle", {21'd0, va}, {21'd0, 9'b000000001, 2'd0});
    applyStimulus(0, 0, 0, 1, 1);
    stall_cycles += int'(a_stall);
    checkOutput("dmiss_compare", {21'd0, va}, {21'd0, 9'b000000001, 2'd0});
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 1, 1'(i % 2));
      stall_cycles += int'(a_stall);
      checkOutput($sformatf("dmiss_wb%0d", i), {21'd0, va}, {21'd0, 9'b100010001, 2'(i / 2)});
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 1'(i % 2));
      stall_cycles += int'(a_stall);
      if (i % 2 == 0) exp_v = 9'b001100001;
      else if (i == 7) exp_v = 9'b011100111;
      else exp_v = 9'b011100001;
      checkOutput($sformatf("dmiss_alloc%0d", i), {21'd0, va}, {21'd0, exp_v, 2'(i / 2)});
    end
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("dmiss_relookup", {21'd0, va}, {21'd0, 9'b100000100, 2'd0});
    checkOutput("dmiss_stall_cycles", stall_cycles, 32'd18);

    // Reset asserted during ALLOCATE beat 2
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_alloc_beat2", {21'd0, va}, {21'd0, 9'b001100001, 2'd2});
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_alloc", {21'd0, va}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_restart_beat0", {21'd0, va}, {21'd0, 9'b011100001, 2'd0});

    // Write miss without allocate: write around, ready after 3 cycles
    doReset();
    memwr_cycles = 0;
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("wa0_idle", {21'd0, vb}, {21'd0, 9'b000000001, 2'd0});
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("wa0_compare", {21'd0, vb}, {21'd0, 9'b000000001, 2'd0});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1'(i == 2));
      memwr_cycles += int'(b_mem_wren);
      exp_v = (i == 2) ? 9'b000010000 : 9'b000010001;
      checkOutput($sformatf("wa0_around%0d", i), {21'd0, vb}, {21'd0, exp_v, 2'd0});
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wa0_back_idle", {21'd0, vb}, 32'd0);
    checkOutput("wa0_memwr_cycles", memwr_cycles, 32'd3);

`ifdef CACHE_LINE_CTRL_PERF_EN
    doReset();
    checkOutput("perf_reset_hit", {30'd0, a_hit_cnt}, 32'd0);
    checkOutput("perf_reset_miss", {30'd0, a_miss_cnt}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("perf_miss_one", {30'd0, a_miss_cnt}, 32'd1);
    checkOutput("perf_relookup_hit", {30'd0, a_hit_cnt}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("perf_hit_saturate", {30'd0, a_hit_cnt}, 32'd3);
    checkOutput("perf_miss_hold", {30'd0, a_miss_cnt}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
